source_pack_store: RTL and testbench

Parametrised packer that gathers a narrow framed byte stream into wide RAM words and stores whole frames into a ring of source RAM banks. Each bank holds a fixed number of frame slots. A bank is handed to the downstream consumer once it is full, and it is refilled only after the consumer releases it. The block sits between the receive front end and the source RAMs. It adds the following over a fixed-geometry saver:
- partial-word padding at frame end
- per-bank full/release handshake
- slot-overflow truncation
- dropped-frame accounting

---
 rtl/source_pack_store.sv | 177 +++++++++++++++++
 tb/tb_source_pack_store.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_pack_store.sv
// Packs a framed IN_W-bit beat stream into WORD_W-bit words and stores whole frames
// into a ring of source RAM banks, handing each full bank to the consumer until released.
module source_pack_store #(
    parameter int IN_W    = 8,
    parameter int WORD_W  = 128,
    parameter int NUM_RAM = 4,
    parameter int FRM_AW  = 2,
    parameter int SLOT_AW = 6,
    parameter int ADDR_W  = FRM_AW + SLOT_AW
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic [NUM_RAM-1:0]        ram_wren,
    output logic [NUM_RAM*ADDR_W-1:0] ram_addr,
    output logic [NUM_RAM*WORD_W-1:0] ram_data,
    output logic [NUM_RAM-1:0]        bank_ready,
    input  logic [NUM_RAM-1:0]        bank_release,
    output logic                      frame_done,
    output logic [SLOT_AW:0]          frame_words,
    output logic                      frame_trunc,
    output logic [15:0]               drop_cnt
);

    localparam int BEATS  = WORD_W / IN_W;
    localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BANK_W = (NUM_RAM > 1) ? $clog2(NUM_RAM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;

    state_t              r_state, w_state_nxt;
    logic [BANK_W-1:0]   r_cur_bank;
    logic [FRM_AW-1:0]   r_slot;
    logic [SLOT_AW-1:0]  r_word_idx;
    logic [LANE_W-1:0]   r_lane;
    logic [WORD_W-1:0]   r_acc;
    logic                r_trunc;
    logic [NUM_RAM-1:0]  r_bank_ready;
    logic [NUM_RAM-1:0]  r_set_pend;
    logic [15:0]         r_drop_cnt;
    logic [NUM_RAM-1:0]  r_wren;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_data;
    logic                r_frame_done;
    logic [SLOT_AW:0]    r_frame_words;
    logic                r_frame_trunc;

    logic [WORD_W-1:0]   w_word;
    logic [NUM_RAM-1:0]  w_bank_oh;
    logic                w_complete;
    logic                w_pack, w_wr, w_commit, w_commit_trunc, w_drop_start, w_enter_trunc;

    assign w_bank_oh  = NUM_RAM'(1) << r_cur_bank;
    assign w_complete = (r_lane == LANE_W'(BEATS - 1)) || in_last;

    // First beat of a word lands in the top lane; later beats fill downward.
    always_comb begin
        w_word = r_acc;
        w_word[WORD_W - 1 - int'(r_lane) * IN_W -: IN_W] = in_data;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pack         = 1'b0;
        w_wr           = 1'b0;
        w_commit       = 1'b0;
        w_commit_trunc = 1'b0;
        w_drop_start   = 1'b0;
        w_enter_trunc  = 1'b0;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (in_valid) begin
                    if (r_state == S_IDLE && r_bank_ready[r_cur_bank]) begin
                        w_drop_start = 1'b1;
                        w_state_nxt  = in_last ? S_IDLE : S_DROP;
                    end else begin
                        w_pack      = 1'b1;
                        w_state_nxt = S_FILL;
                        if (w_complete) begin
                            w_wr = 1'b1;
                            if (in_last) begin
                                w_commit    = 1'b1;
                                w_state_nxt = S_IDLE;
                            end else if (&r_word_idx) begin
                                w_enter_trunc = 1'b1;
                                w_state_nxt   = S_DROP;
                            end
                        end
                    end
                end
            end
            S_DROP: begin
                if (in_valid && in_last) begin
                    w_state_nxt    = S_IDLE;
                    w_commit_trunc = r_trunc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur_bank    <= '0;
            r_slot        <= '0;
            r_word_idx    <= '0;
            r_lane        <= '0;
            r_acc         <= '0;
            r_trunc       <= 1'b0;
            r_bank_ready  <= '0;
            r_set_pend    <= '0;
            r_drop_cnt    <= '0;
            r_wren        <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_words <= '0;
            r_frame_trunc <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wren        <= w_wr ? w_bank_oh : '0;
            r_frame_done  <= w_commit | w_commit_trunc;
            r_frame_trunc <= w_commit_trunc;
            r_set_pend    <= '0;
            // The delayed set lands one cycle after the final write and beats a same-cycle release.
            r_bank_ready  <= (r_bank_ready & ~bank_release) | r_set_pend;

            if (w_pack) begin
                if (w_complete) begin
                    r_acc  <= '0;
                    r_lane <= '0;
                end else begin
                    r_acc  <= w_word;
                    r_lane <= r_lane + LANE_W'(1);
                end
            end

            if (w_wr) begin
                r_addr     <= {r_slot, r_word_idx};
                r_data     <= w_word;
                r_word_idx <= r_word_idx + SLOT_AW'(1);
            end

            if (w_enter_trunc)
                r_trunc <= 1'b1;
            else if (w_state_nxt == S_IDLE)
                r_trunc <= 1'b0;

            if (w_commit || w_commit_trunc) begin
                r_frame_words <= w_commit ? (SLOT_AW + 1)'(r_word_idx) + (SLOT_AW + 1)'(1)
                                          : (SLOT_AW + 1)'(1 << SLOT_AW);
                r_word_idx    <= '0;
                r_slot        <= r_slot + FRM_AW'(1);
                if (&r_slot) begin
                    r_set_pend <= w_bank_oh;
                    r_cur_bank <= (r_cur_bank == BANK_W'(NUM_RAM - 1)) ? '0 : r_cur_bank + BANK_W'(1);
                end
            end

            if (w_drop_start && !(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign ram_wren    = r_wren;
    assign ram_addr    = {NUM_RAM{r_addr}};
    assign ram_data    = {NUM_RAM{r_data}};
    assign bank_ready  = r_bank_ready;
    assign frame_done  = r_frame_done;
    assign frame_words = r_frame_words;
    assign frame_trunc = r_frame_trunc;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_source_pack_store.sv
// Randomized bench for source_pack_store: a frame-level reference model predicts every
// RAM write and frame report, plus cycle checks of reset values and bank handshake timing.
module tb_source_pack_store;

    localparam int IN_W       = 8;
    localparam int WORD_W     = 128;
    localparam int NUM_RAM    = 4;
    localparam int FRM_AW     = 2;
    localparam int SLOT_AW    = 6;
    localparam int ADDR_W     = FRM_AW + SLOT_AW;
    localparam int BEATS      = WORD_W / IN_W;
    localparam int SLOT_WORDS = 1 << SLOT_AW;
    localparam int FRAMES     = 1 << FRM_AW;

    logic                      sys_clk;
    logic                      rst_n;
    logic [IN_W-1:0]           in_data;
    logic                      in_valid;
    logic                      in_last;
    logic [NUM_RAM-1:0]        ram_wren;
    logic [NUM_RAM*ADDR_W-1:0] ram_addr;
    logic [NUM_RAM*WORD_W-1:0] ram_data;
    logic [NUM_RAM-1:0]        bank_ready;
    logic [NUM_RAM-1:0]        bank_release;
    logic                      frame_done;
    logic [SLOT_AW:0]          frame_words;
    logic                      frame_trunc;
    logic [15:0]               drop_cnt;

    source_pack_store #(
        .IN_W(IN_W), .WORD_W(WORD_W), .NUM_RAM(NUM_RAM),
        .FRM_AW(FRM_AW), .SLOT_AW(SLOT_AW), .ADDR_W(ADDR_W)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data),
        .bank_ready(bank_ready), .bank_release(bank_release),
        .frame_done(frame_done), .frame_words(frame_words),
        .frame_trunc(frame_trunc), .drop_cnt(drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0]        bank;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [15:0] words;
        logic        trunc;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    logic [7:0] fbuf[];

    int m_bank, m_slot, m_drops;
    bit m_ready[NUM_RAM];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: decides a whole frame's fate at its start from ring/slot bookkeeping.
    task automatic model_frame(input int len);
        int nw;
        bit tr;
        wr_t w;
        done_t d;
        if (m_ready[m_bank]) begin
            if (m_drops < 65535) m_drops++;
            return;
        end
        nw = (len + BEATS - 1) / BEATS;
        tr = (nw > SLOT_WORDS);
        if (tr) nw = SLOT_WORDS;
        for (int wi = 0; wi < nw; wi++) begin
            w.bank = 8'(m_bank);
            w.addr = ADDR_W'(m_slot * SLOT_WORDS + wi);
            w.data = '0;
            for (int k = 0; k < BEATS; k++) begin
                if (wi * BEATS + k < len)
                    w.data[WORD_W - 1 - 8 * k -: 8] = fbuf[wi * BEATS + k];
            end
            exp_wr.push_back(w);
        end
        d.words = 16'(nw);
        d.trunc = tr;
        exp_done.push_back(d);
        m_slot++;
        if (m_slot == FRAMES) begin
            m_slot = 0;
            m_ready[m_bank] = 1'b1;
            m_bank = (m_bank + 1) % NUM_RAM;
        end
    endtask

    function automatic logic [NUM_RAM-1:0] model_ready_vec();
        logic [NUM_RAM-1:0] v;
        for (int b = 0; b < NUM_RAM; b++) v[b] = m_ready[b];
        return v;
    endfunction

    always @(negedge sys_clk) begin
        if (ram_wren != '0) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", 128'(ram_wren), 128'(0));
            end else begin
                wr_t e;
                logic [NUM_RAM-1:0] oh;
                e = exp_wr.pop_front();
                oh = '0;
                oh[e.bank[1:0]] = 1'b1;
                chk("wr_bank", 128'(ram_wren), 128'(oh));
                chk("wr_addr", 128'(ram_addr[e.bank[1:0] * ADDR_W +: ADDR_W]), 128'(e.addr));
                chk("wr_data", ram_data[e.bank[1:0] * WORD_W +: WORD_W], e.data);
            end
        end
        if (frame_done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 128'(frame_done), 128'(0));
            end else begin
                done_t d;
                d = exp_done.pop_front();
                chk("done_words", 128'(frame_words), 128'(d.words));
                chk("done_trunc", 128'(frame_trunc), 128'(d.trunc));
            end
        end
    end

    task automatic fill_buf(input int len);
        fbuf = new[len];
        for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom);
    endtask

    task automatic drive(input int len, input int stall_pct, input bit with_last,
                         input int rel_beat, input logic [NUM_RAM-1:0] rel_mask);
        for (int i = 0; i < len; i++) begin
            while (int'($urandom_range(99)) < stall_pct) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                bank_release = '0;
                @(posedge sys_clk); #1;
            end
            in_valid = 1'b1;
            in_data = fbuf[i];
            in_last = with_last && (i == len - 1);
            bank_release = (i == rel_beat) ? rel_mask : '0;
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        bank_release = '0;
    endtask

    task automatic frame(input int len, input int stall_pct, input int rel_beat,
                         input logic [NUM_RAM-1:0] rel_mask);
        fill_buf(len);
        model_frame(len);
        if (rel_beat >= 0)
            for (int b = 0; b < NUM_RAM; b++) if (rel_mask[b]) m_ready[b] = 1'b0;
        drive(len, stall_pct, 1'b1, rel_beat, rel_mask);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic release_random();
        int b;
        idle(3);
        b = int'($urandom_range(NUM_RAM - 1));
        for (int k = 0; k < NUM_RAM; k++) begin
            if (m_ready[(b + k) % NUM_RAM]) begin
                bank_release = '0;
                bank_release[(b + k) % NUM_RAM] = 1'b1;
                m_ready[(b + k) % NUM_RAM] = 1'b0;
                @(posedge sys_clk); #1;
                bank_release = '0;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        chk({tag, "_wr_pending"}, 128'(exp_wr.size()), 128'(0));
        chk({tag, "_done_pending"}, 128'(exp_done.size()), 128'(0));
        exp_wr.delete();
        exp_done.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        bank_release = '0;
        idle(2);
        rst_n = 1'b1;
        m_bank = 0;
        m_slot = 0;
        m_drops = 0;
        for (int b = 0; b < NUM_RAM; b++) m_ready[b] = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge sys_clk);
        chk({tag, "_wren"}, 128'(ram_wren), 128'(0));
        chk({tag, "_addr"}, 128'(ram_addr), 128'(0));
        chk({tag, "_data_nz"}, 128'(ram_data != '0), 128'(0));
        chk({tag, "_ready"}, 128'(bank_ready), 128'(0));
        chk({tag, "_done"}, 128'(frame_done), 128'(0));
        chk({tag, "_words"}, 128'(frame_words), 128'(0));
        chk({tag, "_trunc"}, 128'(frame_trunc), 128'(0));
        chk({tag, "_drops"}, 128'(drop_cnt), 128'(0));
        @(posedge sys_clk); #1;
    endtask

    initial begin
        in_data = '0;
        exp_wr.delete();
        exp_done.delete();
        apply_reset();
        check_reset_vals("rst");

        // Long frame, then short frame with zero-padded tail.
        frame(944, 10, -1, '0);
        frame(20, 0, -1, '0);
        drain("basic");

        // Four slots fill bank 0; ready rises one cycle after its last write.
        apply_reset();
        for (int f = 0; f < 3; f++) frame(100, 0, -1, '0);
        frame(100, 0, -1, '0);
        @(negedge sys_clk);
        chk("last_write_done", 128'(frame_done), 128'(1));
        chk("ready_not_yet", 128'(bank_ready), 128'(0));
        @(negedge sys_clk);
        chk("ready_bank0", 128'(bank_ready), 128'(4'b0001));
        @(posedge sys_clk); #1;
        frame(100, 0, -1, '0);
        drain("ring");

        // All banks full: next frame dropped even with a mid-frame release.
        apply_reset();
        for (int f = 0; f < 16; f++) frame(int'($urandom_range(1, 120)), 20, -1, '0);
        idle(3);
        chk("all_ready", 128'(bank_ready), 128'(4'hF));
        frame(50, 0, 10, 4'b0001);
        idle(3);
        chk("drop_one", 128'(drop_cnt), 128'(1));
        chk("ready_after_rel", 128'(bank_ready), 128'(4'hE));
        frame(40, 0, -1, '0);
        drain("full");

        // Slot overflow truncation and the exact-fit boundary.
        apply_reset();
        frame(1100, 5, -1, '0);
        frame(1024, 0, -1, '0);
        frame(1025, 0, -1, '0);
        idle(2);
        chk("trunc_no_drop", 128'(drop_cnt), 128'(0));
        drain("trunc");

        // Reset in the middle of a frame discards the partial word.
        apply_reset();
        fill_buf(10);
        drive(10, 0, 1'b0, -1, '0);
        apply_reset();
        check_reset_vals("midrst");
        frame(16, 0, -1, '0);
        drain("midrst");

        // Random traffic with stalls, back-to-back frames and releases.
        apply_reset();
        for (int f = 0; f < 60; f++) begin
            int len, sel;
            len = ($urandom_range(9) == 0) ? int'($urandom_range(1000, 1100))
                                           : int'($urandom_range(1, 200));
            frame(len, int'($urandom_range(30)), -1, '0);
            sel = int'($urandom_range(2));
            if (sel == 0) release_random();
            else if (sel == 1) idle(1);
        end
        idle(4);
        chk("rand_drops", 128'(drop_cnt), 128'(m_drops));
        chk("rand_ready", 128'(bank_ready), 128'(model_ready_vec()));
        drain("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
